// File: rtl/ysyx_040750_clint_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040750_clint_pkg
//   Shared constants and helpers for the core-local interruptor (CLINT).
//   - Register offsets inside the CLINT window and the window base address
//     used by the LSU bus decoder.
//   - Reset value of mtimecmp.
//   - Request/response FSM state encoding.
//   - Offset decoder and byte-lane merge helper.
// ---------------------------------------------------------------------------
package ysyx_040750_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CLINT_BASE   = 64'h0000_0000_0200_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_e;

  typedef enum logic [1:0] {
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME,
    REG_NONE
  } clint_reg_e;

  // Maps a byte offset onto a register; anything else is unmapped.
  function automatic clint_reg_e decode_off(input logic [15:0] off);
    clint_reg_e r;
    case (off)
      MSIP_OFF:     r = REG_MSIP;
      MTIMECMP_OFF: r = REG_MTIMECMP;
      MTIME_OFF:    r = REG_MTIME;
      default:      r = REG_NONE;
    endcase
    return r;
  endfunction

  // Per-byte merge: lane i takes the new byte when its strobe is set.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  wmask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = wmask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_040750_clint_if.sv
// ---------------------------------------------------------------------------
// ysyx_040750_clint_if
//   Single-outstanding MMIO request/response port between the LSU bus
//   decoder (master) and the CLINT (slave).
//   Request : I_req_valid / O_req_ready, I_req_wen, I_req_addr (16-bit byte
//             offset), I_req_wdata (64), I_req_wmask (8 byte strobes).
//   Response: O_rsp_valid / I_rsp_ready, O_rsp_rdata (64), O_rsp_err.
//   Signal names keep the I_/O_ prefixes as seen from the CLINT side.
// ---------------------------------------------------------------------------
interface ysyx_040750_clint_if;

  logic        I_req_valid;
  logic        O_req_ready;
  logic        I_req_wen;
  logic [15:0] I_req_addr;
  logic [63:0] I_req_wdata;
  logic [7:0]  I_req_wmask;
  logic        O_rsp_valid;
  logic        I_rsp_ready;
  logic [63:0] O_rsp_rdata;
  logic        O_rsp_err;

  modport master (
    output I_req_valid, I_req_wen, I_req_addr, I_req_wdata, I_req_wmask,
    output I_rsp_ready,
    input  O_req_ready, O_rsp_valid, O_rsp_rdata, O_rsp_err
  );

  modport slave (
    input  I_req_valid, I_req_wen, I_req_addr, I_req_wdata, I_req_wmask,
    input  I_rsp_ready,
    output O_req_ready, O_rsp_valid, O_rsp_rdata, O_rsp_err
  );

endinterface

// File: rtl/ysyx_040750_clint_mtime.sv
// ---------------------------------------------------------------------------
// ysyx_040750_clint_mtime
//   Free-running machine timer: a prescaler that emits one tick every
//   TICK_DIV core clocks and a 64-bit mtime counter advanced on each tick.
//   Ports:
//     clk, rst_n : core clock, asynchronous active-low reset
//     wen        : software write to mtime this cycle
//     wmask      : byte strobes of the write
//     wdata      : write data, byte lanes aligned to the 8-byte word
//     mtime      : current counter value
//     tick       : prescaler terminal count (mtime advances this cycle)
// ---------------------------------------------------------------------------
module ysyx_040750_clint_mtime
  import ysyx_040750_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [7:0]  wmask,
  input  logic [63:0] wdata,
  output logic [63:0] mtime,
  output logic        tick
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q;
  logic        sw_wr;

  assign tick = (presc_q == DIV_LAST);

  // An all-zero strobe carries no bytes, so it must not suppress a tick.
  assign sw_wr = wen && (wmask != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
    end else if (tick) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Software write has priority over the tick increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= 64'd0;
    end else if (sw_wr) begin
      mtime <= merge_bytes(mtime, wdata, wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_040750_clint.sv
// ---------------------------------------------------------------------------
// ysyx_040750_clint
//   Core-local interruptor: holds msip, mtimecmp and mtime and serves them
//   over a single-outstanding MMIO port.
//   Register map (byte offsets): 0x0000 msip (bit 0), 0x4000 mtimecmp,
//   0xBFF8 mtime. Misaligned or unmapped offsets answer with O_rsp_err.
//   Ports:
//     I_sys_clk, I_rst_n : core clock, asynchronous active-low reset
//     bus                : MMIO request/response port (slave side)
//     O_mtip             : registered (mtime >= mtimecmp), unsigned
//     O_msip             : software interrupt pending bit
//     O_mtime            : live mtime, feeds the time CSR
// ---------------------------------------------------------------------------
module ysyx_040750_clint
  import ysyx_040750_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                    I_sys_clk,
  input  logic                    I_rst_n,
  ysyx_040750_clint_if.slave      bus,
  output logic                    O_mtip,
  output logic                    O_msip,
  output logic [63:0]             O_mtime
);

  clint_state_e state_q, state_d;
  clint_reg_e   sel;

  logic        accept;
  logic        err;
  logic        wr;
  logic [63:0] rd_val;

  logic        msip_q;
  logic [63:0] mtimecmp_q;
  logic        mtip_q;
  logic [63:0] mtime;
  logic        tick_unused;

  logic [63:0] rdata_q;
  logic        err_q;

  // ---- request decode ----
  assign sel    = decode_off(bus.I_req_addr);
  assign err    = (bus.I_req_addr[2:0] != 3'b000) || (sel == REG_NONE);
  assign accept = bus.I_req_valid && (state_q == IDLE);
  assign wr     = accept && bus.I_req_wen && !err;

  always_comb begin
    rd_val = 64'd0;
    case (sel)
      REG_MSIP:     rd_val = {63'd0, msip_q};
      REG_MTIMECMP: rd_val = mtimecmp_q;
      REG_MTIME:    rd_val = mtime;
      default:      rd_val = 64'd0;
    endcase
  end

  // ---- request/response FSM ----
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.O_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.O_req_ready = 1'b1;
        if (bus.I_req_valid) state_d = RESP;
      end
      RESP: begin
        if (bus.I_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload is captured at accept from pre-write register values
  // and held untouched for the whole RESP phase.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (!bus.I_req_wen && !err) ? rd_val : 64'd0;
    end
  end

  assign bus.O_rsp_valid = (state_q == RESP);
  assign bus.O_rsp_rdata = rdata_q;
  assign bus.O_rsp_err   = err_q;

  // ---- msip / mtimecmp registers ----
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      msip_q <= 1'b0;
    end else if (wr && (sel == REG_MSIP) && bus.I_req_wmask[0]) begin
      msip_q <= bus.I_req_wdata[0];
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtimecmp_q <= MTIMECMP_RST;
    end else if (wr && (sel == REG_MTIMECMP)) begin
      mtimecmp_q <= merge_bytes(mtimecmp_q, bus.I_req_wdata, bus.I_req_wmask);
    end
  end

  // ---- timer ----
  ysyx_040750_clint_mtime #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (I_sys_clk),
    .rst_n (I_rst_n),
    .wen   (wr && (sel == REG_MTIME)),
    .wmask (bus.I_req_wmask),
    .wdata (bus.I_req_wdata),
    .mtime (mtime),
    .tick  (tick_unused)
  );

  // Compare result is registered, so O_mtip trails register changes by one
  // cycle; it drops only once mtimecmp (or mtime) moves the compare false.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mtip_q <= 1'b0;
    end else begin
      mtip_q <= (mtime >= mtimecmp_q);
    end
  end

  assign O_mtip  = mtip_q;
  assign O_msip  = msip_q;
  assign O_mtime = mtime;

endmodule

// File: tb/tb_ysyx_040750_clint.sv
// ---------------------------------------------------------------------------
// tb_ysyx_040750_clint
//   Directed bench for the CLINT. Two instances share clock, reset and the
//   request payload: index 0 runs with TICK_DIV=1, index 1 with TICK_DIV=4.
//   Each instance has its own valid / rsp_ready so only one is addressed.
// ---------------------------------------------------------------------------
module tb_ysyx_040750_clint;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic        req_wen;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;

  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [63:0] rsp_rdata [2];
  logic [1:0]  mtip;
  logic [1:0]  msip;
  logic [63:0] mtime [2];

  int unsigned cyc;
  int          n_vec;
  int          n_miscmp;
  logic [63:0] mt_at_rsp;

  always #5 clk = ~clk;

  // Edges seen with reset released; TICK_DIV=4 ticks on multiples of 4.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  ysyx_040750_clint_if bus1 ();
  ysyx_040750_clint_if bus4 ();

  assign bus1.I_req_valid = req_valid[0];
  assign bus1.I_rsp_ready = rsp_ready[0];
  assign bus1.I_req_wen   = req_wen;
  assign bus1.I_req_addr  = req_addr;
  assign bus1.I_req_wdata = req_wdata;
  assign bus1.I_req_wmask = req_wmask;
  assign bus4.I_req_valid = req_valid[1];
  assign bus4.I_rsp_ready = rsp_ready[1];
  assign bus4.I_req_wen   = req_wen;
  assign bus4.I_req_addr  = req_addr;
  assign bus4.I_req_wdata = req_wdata;
  assign bus4.I_req_wmask = req_wmask;

  assign req_ready[0] = bus1.O_req_ready;
  assign rsp_valid[0] = bus1.O_rsp_valid;
  assign rsp_err[0]   = bus1.O_rsp_err;
  assign rsp_rdata[0] = bus1.O_rsp_rdata;
  assign req_ready[1] = bus4.O_req_ready;
  assign rsp_valid[1] = bus4.O_rsp_valid;
  assign rsp_err[1]   = bus4.O_rsp_err;
  assign rsp_rdata[1] = bus4.O_rsp_rdata;

  ysyx_040750_clint #(.TICK_DIV(1)) dut1 (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n),
    .bus       (bus1),
    .O_mtip    (mtip[0]),
    .O_msip    (msip[0]),
    .O_mtime   (mtime[0])
  );

  ysyx_040750_clint #(.TICK_DIV(4)) dut4 (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n),
    .bus       (bus4),
    .O_mtip    (mtip[1]),
    .O_msip    (msip[1]),
    .O_mtime   (mtime[1])
  );

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full request/response; fixed one-cycle response latency.
  task automatic xact(input int s, input logic wen, input logic [15:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      output logic [63:0] rdata, output logic err);
    check_vec("req_ready", {63'd0, req_ready[s]}, 64'd1);
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_wmask    = wmask;
    req_valid[s] = 1'b1;
    step(1);
    req_valid[s] = 1'b0;
    check_vec("rsp_valid", {63'd0, rsp_valid[s]}, 64'd1);
    rdata        = rsp_rdata[s];
    err          = rsp_err[s];
    mt_at_rsp    = mtime[s];
    rsp_ready[s] = 1'b1;
    step(1);
    rsp_ready[s] = 1'b0;
  endtask

  task automatic align_tick4();
    while (((cyc + 1) % 4) != 0) step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          n;

    n_vec = 0; n_miscmp = 0;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; req_wen = 1'b0;
    req_addr = 16'h0; req_wdata = 64'd0; req_wmask = 8'h00;
    step(2);
    check_vec("rst_mtime", mtime[0], 64'd0);
    check_vec("rst_mtip", {63'd0, mtip[0]}, 64'd0);
    check_vec("rst_msip", {63'd0, msip[0]}, 64'd0);
    check_vec("rst_rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
    check_vec("rst_req_ready", {63'd0, req_ready[0]}, 64'd1);
    check_vec("rst_rdata", rsp_rdata[0], 64'd0);
    rst_n = 1'b1;

    // Free run: TICK_DIV=1 counts every edge, TICK_DIV=4 on edges 4,8,...
    step(3);
    check_vec("div1_c3", mtime[0], 64'd3);
    check_vec("div4_c3", mtime[1], 64'd0);
    step(1);
    check_vec("div4_c4", mtime[1], 64'd1);
    step(6);
    check_vec("div1_c10", mtime[0], 64'd10);
    check_vec("div4_c10", mtime[1], 64'd2);
    check_vec("c10_mtip", {63'd0, mtip[0]}, 64'd0);
    check_vec("c10_msip", {63'd0, msip[0]}, 64'd0);

    xact(0, 1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    check_vec("cmp_rst_rd", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check_vec("cmp_rst_err", {63'd0, er}, 64'd0);

    // mtimecmp = 20: mtip rises one cycle after mtime reaches 20.
    xact(0, 1'b1, 16'h4000, 64'd20, 8'hFF, rd, er);
    check_vec("cmp_wr_err", {63'd0, er}, 64'd0);
    check_vec("cmp_wr_rdata", rd, 64'd0);
    n = 0;
    while (mtime[0] != 64'd20 && n < 40) begin
      step(1);
      n++;
    end
    check_vec("reach20", mtime[0], 64'd20);
    check_vec("mtip_pre", {63'd0, mtip[0]}, 64'd0);
    step(1);
    check_vec("mtip_rise", {63'd0, mtip[0]}, 64'd1);

    xact(0, 1'b1, 16'h4000, 64'd1000, 8'hFF, rd, er);
    check_vec("mtip_clr", {63'd0, mtip[0]}, 64'd0);

    // Write wins over the every-cycle tick.
    xact(0, 1'b1, 16'hBFF8, 64'd100, 8'hFF, rd, er);
    check_vec("mtime_wr", mt_at_rsp, 64'd100);
    check_vec("mtime_wr_next", mtime[0], 64'd101);
    xact(0, 1'b0, 16'hBFF8, 64'd0, 8'h00, rd, er);
    check_vec("mtime_rd_pre", rd, mt_at_rsp - 64'd1);

    // Error accesses.
    xact(0, 1'b0, 16'hBFF4, 64'd0, 8'h00, rd, er);
    check_vec("misalign_err", {63'd0, er}, 64'd1);
    check_vec("misalign_rd", rd, 64'd0);
    xact(0, 1'b0, 16'h1000, 64'd0, 8'h00, rd, er);
    check_vec("unmapped_err", {63'd0, er}, 64'd1);
    check_vec("unmapped_rd", rd, 64'd0);
    xact(0, 1'b1, 16'h4004, 64'd5, 8'hFF, rd, er);
    check_vec("err_wr_err", {63'd0, er}, 64'd1);
    xact(0, 1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    check_vec("err_wr_nochg", rd, 64'd1000);
    check_vec("err_wr_ok", {63'd0, er}, 64'd0);

    // msip.
    xact(0, 1'b1, 16'h0000, 64'd1, 8'h01, rd, er);
    check_vec("msip_wr_err", {63'd0, er}, 64'd0);
    check_vec("msip_set", {63'd0, msip[0]}, 64'd1);
    xact(0, 1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    check_vec("msip_rd", rd, 64'd1);
    xact(0, 1'b1, 16'h0000, 64'd0, 8'h00, rd, er);
    check_vec("msip_mask0", {63'd0, msip[0]}, 64'd1);
    xact(0, 1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFE, rd, er);
    check_vec("msip_lane0_only", {63'd0, msip[0]}, 64'd1);
    xact(0, 1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    check_vec("msip_rd_bits", rd, 64'd1);

    // TICK_DIV=4: write all-ones on a tick edge, wrap on the next tick.
    align_tick4();
    xact(1, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er);
    check_vec("wrap_wr", mt_at_rsp, 64'hFFFF_FFFF_FFFF_FFFF);
    check_vec("wrap_hold", mtime[1], 64'hFFFF_FFFF_FFFF_FFFF);
    step(3);
    check_vec("wrap_zero", mtime[1], 64'd0);

    // Partial write on a tick edge: low four lanes replaced, no increment.
    xact(1, 1'b1, 16'hBFF8, 64'h0000_00AA_0000_0000, 8'hFF, rd, er);
    align_tick4();
    xact(1, 1'b1, 16'hBFF8, 64'h1234_5678_DEAD_BEEF, 8'h0F, rd, er);
    check_vec("partial_wr", mt_at_rsp, 64'h0000_00AA_DEAD_BEEF);
    check_vec("partial_hold", mtime[1], 64'h0000_00AA_DEAD_BEEF);

    // Stall the response for 5 cycles with a competing request pending.
    req_wen = 1'b0; req_addr = 16'h4000; req_valid[0] = 1'b1;
    step(1);
    req_addr = 16'hBFF8;
    for (int i = 0; i < 5; i++) begin
      check_vec("stall_valid", {63'd0, rsp_valid[0]}, 64'd1);
      check_vec("stall_rdata", rsp_rdata[0], 64'd1000);
      check_vec("stall_ready", {63'd0, req_ready[0]}, 64'd0);
      step(1);
    end
    req_valid[0] = 1'b0;

    // Asynchronous reset while in RESP.
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst_rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
    check_vec("arst_req_ready", {63'd0, req_ready[0]}, 64'd1);
    check_vec("arst_rdata", rsp_rdata[0], 64'd0);
    check_vec("arst_mtime1", mtime[0], 64'd0);
    check_vec("arst_mtime4", mtime[1], 64'd0);
    check_vec("arst_msip", {63'd0, msip[0]}, 64'd0);
    check_vec("arst_mtip", {63'd0, mtip[0]}, 64'd0);
    step(1);
    rst_n = 1'b1;
    xact(0, 1'b0, 16'h4000, 64'd0, 8'h00, rd, er);
    check_vec("arst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    xact(0, 1'b0, 16'h0000, 64'd0, 8'h00, rd, er);
    check_vec("arst_msip_rd", rd, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
